// File: rtl/syncmem_wait.sv
// Single-port synchronous word memory with byte enables, programmable wait states and range errors.
// Optional read/write completion counters are built when SYNCMEM_STATS_EN is defined.
module syncmem_wait #(
    parameter int    DATA_W      = 32,
    parameter int    ADDR_W      = 30,
    parameter int    DEPTH_LOG2  = 12,
    parameter int    WAIT_STATES = 0,
    parameter string INIT_FILE   = ""
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  re,
    input  logic                  we,
    input  logic [DATA_W/8-1:0]   be,
    input  logic [ADDR_W-1:0]     addr,
    input  logic [DATA_W-1:0]     wdata,
    output logic                  ready,
    output logic [DATA_W-1:0]     rdata,
    output logic                  rvalid,
    output logic                  err,
    output logic [15:0]           rd_cnt,
    output logic [15:0]           wr_cnt
);
    localparam int NB    = DATA_W / 8;
    localparam int DEPTH = 1 << DEPTH_LOG2;

    typedef enum logic {IDLE, WAIT} state_t;

    // Handshake: a request is taken on a posedge where ready=1 and (re|we);
    // while ready=0 all request inputs are ignored. Completion is signalled
    // by the one-cycle rvalid (reads) and err (out-of-range) pulses.
    state_t              state;
    logic [7:0]          wait_cnt;
    logic                lat_re;
    logic                lat_we;
    logic [NB-1:0]       lat_be;
    logic [ADDR_W-1:0]   lat_addr;
    logic [DATA_W-1:0]   lat_wdata;
    logic [DATA_W-1:0]   mem [DEPTH];

    logic                accept;
    logic                complete;
    logic                acc_re;
    logic                acc_we;
    logic [NB-1:0]       acc_be;
    logic [ADDR_W-1:0]   acc_addr;
    logic [DATA_W-1:0]   acc_wdata;
    logic                in_range;
    logic [DEPTH_LOG2-1:0] idx;
    logic                do_rd;
    logic                do_wr;

    assign accept = (state == IDLE) && (re || we);

    // Without wait states the access completes on its own acceptance edge, using the live inputs.
    always_comb begin
        acc_re    = lat_re;
        acc_we    = lat_we;
        acc_be    = lat_be;
        acc_addr  = lat_addr;
        acc_wdata = lat_wdata;
        complete  = (state == WAIT) && (wait_cnt == 8'd0);
        if (WAIT_STATES == 0) begin
            acc_re    = re;
            acc_we    = we;
            acc_be    = be;
            acc_addr  = addr;
            acc_wdata = wdata;
            complete  = accept;
        end
    end

    assign in_range = (acc_addr[ADDR_W-1:DEPTH_LOG2] == '0);
    assign idx      = acc_addr[DEPTH_LOG2-1:0];
    assign do_rd    = complete && acc_re;
    assign do_wr    = complete && acc_we && in_range;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            ready     <= 1'b1;
            rdata     <= '0;
            rvalid    <= 1'b0;
            err       <= 1'b0;
            wait_cnt  <= 8'd0;
            lat_re    <= 1'b0;
            lat_we    <= 1'b0;
            lat_be    <= '0;
            lat_addr  <= '0;
            lat_wdata <= '0;
        end else begin
            rvalid <= do_rd;
            err    <= complete && !in_range;
            if (do_rd) begin
                rdata <= in_range ? mem[idx] : '0;
            end
            case (state)
                IDLE: begin
                    if (accept) begin
                        lat_re    <= re;
                        lat_we    <= we;
                        lat_be    <= be;
                        lat_addr  <= addr;
                        lat_wdata <= wdata;
                        if (WAIT_STATES != 0) begin
                            state    <= WAIT;
                            ready    <= 1'b0;
                            wait_cnt <= 8'(WAIT_STATES - 1);
                        end
                    end
                end
                WAIT: begin
                    if (wait_cnt == 8'd0) begin
                        state <= IDLE;
                        ready <= 1'b1;
                    end else begin
                        wait_cnt <= wait_cnt - 8'd1;
                    end
                end
                default: begin
                    state <= IDLE;
                    ready <= 1'b1;
                end
            endcase
        end
    end

    // Array storage is deliberately outside the reset domain: reset leaves contents intact.
    always_ff @(posedge clk) begin
        if (do_wr) begin
            for (int i = 0; i < NB; i++) begin
                if (acc_be[i]) begin
                    mem[idx][8*i +: 8] <= acc_wdata[8*i +: 8];
                end
            end
        end
    end

`ifdef SYNCMEM_STATS_EN
    // Out-of-range accesses still count as completed; counters stick at all-ones.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_cnt <= 16'd0;
            wr_cnt <= 16'd0;
        end else begin
            if (do_rd && rd_cnt != 16'hFFFF) begin
                rd_cnt <= rd_cnt + 16'd1;
            end
            if (complete && acc_we && wr_cnt != 16'hFFFF) begin
                wr_cnt <= wr_cnt + 16'd1;
            end
        end
    end
`else
    assign rd_cnt = 16'd0;
    assign wr_cnt = 16'd0;
`endif

endmodule
